// File: rtl/am_rm_bip_rx_pkg.sv
// Shared PCS definitions for the lane receive path: block geometry, sync headers,
// alignment-marker byte positions and the marker-check state encoding.
package am_rm_bip_rx_pkg;

  localparam int unsigned HEAD_W  = 2;
  localparam int unsigned BLOCK_W = 66;
  localparam int unsigned BIP_W   = 8;

  localparam logic [HEAD_W-1:0] SYNC_CTRL = 2'b01;
  localparam logic [HEAD_W-1:0] SYNC_DATA = 2'b10;

  localparam int unsigned BIP3_IDX = 3;
  localparam int unsigned BIP7_IDX = 7;

  typedef enum logic [1:0] {
    ST_UNLOCK = 2'd0,
    ST_WAIT   = 2'd1,
    ST_RUN    = 2'd2
  } rx_state_e;

endpackage

// File: rtl/am_rm_bip_rx_if.sv
// Block stream bundle between marker lock and deskew; the stage under test is the slave,
// whoever feeds blocks and consumes the filtered stream is the master.
interface am_rm_bip_rx_if
  import am_rm_bip_rx_pkg::*;
#(
  parameter int unsigned CNT_W = 16
);

  logic               valid_i;
  logic [BLOCK_W-1:0] block_i;
  logic               lock_v_i;
  logic               am_v_i;
  logic               valid_o;
  logic [BLOCK_W-1:0] block_o;
  logic               bip_err_o;
  logic [CNT_W-1:0]   err_cnt_o;

  modport master (
    output valid_i, block_i, lock_v_i, am_v_i,
    input  valid_o, block_o, bip_err_o, err_cnt_o
  );

  modport slave (
    input  valid_i, block_i, lock_v_i, am_v_i,
    output valid_o, block_o, bip_err_o, err_cnt_o
  );

endinterface

// File: rtl/am_rm_bip_rx_bip8_calc.sv
// BIP-8 contribution of one 66-bit block: payload bit p lands on parity bit (p-2) mod 8,
// sync header bits 0/1 land on parity bits 3/4.
module bip8_calc
  import am_rm_bip_rx_pkg::*;
(
  input  logic [BLOCK_W-1:0] block,
  output logic [BIP_W-1:0]   bip
);

  always_comb begin
    bip = '0;
    for (int unsigned p = HEAD_W; p < BLOCK_W; p++) begin
      bip[(p - HEAD_W) % BIP_W] = bip[(p - HEAD_W) % BIP_W] ^ block[p];
    end
    bip[3] = bip[3] ^ block[0];
    bip[4] = bip[4] ^ block[1];
  end

endmodule

// File: rtl/am_rm_bip_rx.sv
// Per-lane marker BIP3 checker and marker remover: one-cycle registered pass-through
// of data blocks, markers dropped, BIP3 mismatches pulsed and counted with saturation.
module am_rm_bip_rx
  import am_rm_bip_rx_pkg::*;
#(
  parameter int unsigned CNT_W = 16
)(
  input  logic         clk,
  input  logic         nreset,
  am_rm_bip_rx_if.slave rx
);

  rx_state_e          state_q, state_d;
  logic [BIP_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               chk_err;
  logic               valid_d;
  logic [BIP_W-1:0]   blk_bip;
  logic [BIP_W-1:0]   rx_bip3;

  bip8_calc u_bip8 (
    .block (rx.block_i),
    .bip   (blk_bip)
  );

  assign rx_bip3 = rx.block_i[HEAD_W + BIP_W*BIP3_IDX +: BIP_W];

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= ST_UNLOCK;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
    end
  end

  // Lock loss overrides everything, including idle (valid_i = 0) cycles.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    chk_err = 1'b0;
    if (!rx.lock_v_i) begin
      state_d = ST_UNLOCK;
      acc_d   = '0;
    end else begin
      unique case (state_q)
        ST_UNLOCK: begin
          state_d = ST_WAIT;
          acc_d   = '0;
        end
        ST_WAIT: begin
          if (rx.valid_i && rx.am_v_i) begin
            acc_d   = blk_bip;
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (rx.valid_i) begin
            if (rx.am_v_i) begin
              chk_err = (acc_q != rx_bip3);
              acc_d   = blk_bip;
            end else begin
              acc_d   = acc_q ^ blk_bip;
            end
          end
        end
        default: begin
          state_d = ST_UNLOCK;
          acc_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (chk_err && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign valid_d = rx.valid_i & rx.lock_v_i & ~rx.am_v_i & (state_q != ST_UNLOCK);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cnt_q        <= '0;
      rx.valid_o   <= 1'b0;
      rx.block_o   <= '0;
      rx.bip_err_o <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      rx.valid_o   <= valid_d;
      rx.block_o   <= rx.block_i;
      rx.bip_err_o <= chk_err;
    end
  end

  assign rx.err_cnt_o = cnt_q;

endmodule

// File: tb/tb_am_rm_bip_rx.sv
// Scoreboard bench for am_rm_bip_rx: a behavioural lane model predicts each cycle's
// outputs, which are queued at drive time and compared one clock later.
module tb_am_rm_bip_rx;
  import am_rm_bip_rx_pkg::*;

  typedef struct packed {
    logic               v;
    logic               e;
    logic [15:0]        c;
    logic [BLOCK_W-1:0] b;
  } exp_t;

  logic clk = 1'b0;
  logic nreset;
  int   n_total = 0;
  int   n_bad   = 0;

  exp_t sb_q[$];

  int          m_state;
  logic [7:0]  m_acc;
  logic [15:0] m_cnt;

  am_rm_bip_rx_if #(.CNT_W(16)) rx_if ();

  am_rm_bip_rx #(.CNT_W(16)) dut (
    .clk    (clk),
    .nreset (nreset),
    .rx     (rx_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [BLOCK_W-1:0] act, input logic [BLOCK_W-1:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] ref_bip(input logic [BLOCK_W-1:0] b);
    logic [7:0] x;
    x = '0;
    for (int k = 0; k < 8; k++) x ^= b[2 + 8*k +: 8];
    x[3] ^= b[0];
    x[4] ^= b[1];
    return x;
  endfunction

  function automatic logic [BLOCK_W-1:0] mk_am(input logic [7:0] bip3);
    return {~bip3, 8'hDE, 8'h97, 8'h3E, bip3, 8'h21, 8'h68, 8'hC1, SYNC_CTRL};
  endfunction

  function automatic logic [BLOCK_W-1:0] rnd_data();
    return {$urandom(), $urandom(), SYNC_DATA};
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_acc   = '0;
    m_cnt   = '0;
  endtask

  // One clock: drive, predict, then compare the DUT against the oldest prediction.
  task automatic cyc(input logic v, input logic l, input logic a, input logic [BLOCK_W-1:0] b);
    exp_t x;
    exp_t got;
    logic [7:0] p;
    rx_if.valid_i  = v;
    rx_if.lock_v_i = l;
    rx_if.am_v_i   = a;
    rx_if.block_i  = b;
    p   = ref_bip(b);
    x.v = v & l & ~a & (m_state != 0);
    x.e = 1'b0;
    x.b = b;
    if (!l) begin
      m_state = 0;
      m_acc   = '0;
    end else if (m_state == 0) begin
      m_state = 1;
    end else if (m_state == 1) begin
      if (v && a) begin
        m_acc   = p;
        m_state = 2;
      end
    end else if (v) begin
      if (a) begin
        if (m_acc != b[26 +: 8]) begin
          x.e = 1'b1;
          if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end
        m_acc = p;
      end else begin
        m_acc = m_acc ^ p;
      end
    end
    x.c = m_cnt;
    sb_q.push_back(x);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    check("valid_o",   rx_if.valid_o,   got.v);
    check("bip_err_o", rx_if.bip_err_o, got.e);
    check("err_cnt_o", rx_if.err_cnt_o, got.c);
    check("block_o",   rx_if.block_o,   got.b);
  endtask

  task automatic do_reset();
    nreset = 1'b0;
    #1;
    check("rst_valid", rx_if.valid_o,   '0);
    check("rst_block", rx_if.block_o,   '0);
    check("rst_err",   rx_if.bip_err_o, '0);
    check("rst_cnt",   rx_if.err_cnt_o, '0);
    check("rst_state", 66'(dut.state_q), 66'(ST_UNLOCK));
    model_reset();
    @(negedge clk);
    nreset = 1'b1;
  endtask

  task automatic lock_m1(input logic [7:0] bip3);
    cyc(1'b1, 1'b1, 1'b0, rnd_data());
    cyc(1'b1, 1'b1, 1'b1, mk_am(bip3));
  endtask

  initial begin
    logic [7:0]         clean;
    logic [BLOCK_W-1:0] blk;
    nreset         = 1'b0;
    rx_if.valid_i  = 1'b0;
    rx_if.lock_v_i = 1'b0;
    rx_if.am_v_i   = 1'b0;
    rx_if.block_i  = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("init_cnt",   rx_if.err_cnt_o, '0);
    check("init_valid", rx_if.valid_o,   '0);
    @(negedge clk);
    nreset = 1'b1;

    // Clean long run between two markers.
    lock_m1(8'h00);
    repeat (16383) cyc(1'b1, 1'b1, 1'b0, rnd_data());
    cyc(1'b1, 1'b1, 1'b1, mk_am(m_acc));
    check("good_m2_err", rx_if.bip_err_o, '0);
    check("good_m2_cnt", rx_if.err_cnt_o, '0);

    rx_if.valid_i = 1'b1;
    rx_if.lock_v_i = 1'b1;
    rx_if.block_i = rnd_data();
    do_reset();

    // M2 BIP3 with bit 4 flipped.
    lock_m1(8'h5A);
    repeat (200) cyc(1'b1, 1'b1, 1'b0, rnd_data());
    cyc(1'b1, 1'b1, 1'b1, mk_am(m_acc ^ 8'h10));
    check("bip3_flip_err", rx_if.bip_err_o, 66'd1);
    check("bip3_flip_cnt", rx_if.err_cnt_o, 66'd1);
    cyc(1'b1, 1'b1, 1'b0, rnd_data());
    check("pulse_width", rx_if.bip_err_o, '0);
    do_reset();

    // One data block with header bit 1 corrupted; BIP3 carries the clean parity.
    lock_m1(8'h00);
    clean = m_acc;
    for (int i = 0; i < 200; i++) begin
      blk   = rnd_data();
      clean = clean ^ ref_bip(blk);
      if (i == 77) blk[1] = ~blk[1];
      cyc(1'b1, 1'b1, 1'b0, blk);
    end
    cyc(1'b1, 1'b1, 1'b1, mk_am(clean));
    check("hdr_flip_err", rx_if.bip_err_o, 66'd1);
    check("hdr_flip_cnt", rx_if.err_cnt_o, 66'd1);
    do_reset();

    // First marker after lock is never checked.
    lock_m1(8'hA5);
    check("first_am_err", rx_if.bip_err_o, '0);
    repeat (50) cyc(1'b1, 1'b1, 1'b0, rnd_data());
    cyc(1'b1, 1'b1, 1'b1, mk_am(m_acc ^ 8'h80));
    check("second_am_cnt", rx_if.err_cnt_o, 66'd1);

    // One-cycle lock drop: following marker is a WAIT marker, counter untouched.
    repeat (10) cyc(1'b1, 1'b1, 1'b0, rnd_data());
    cyc(1'b1, 1'b0, 1'b0, rnd_data());
    cyc(1'b1, 1'b1, 1'b0, rnd_data());
    repeat (5) cyc(1'b1, 1'b1, 1'b0, rnd_data());
    cyc(1'b1, 1'b1, 1'b1, mk_am(m_acc ^ 8'h01));
    check("relock_am_err", rx_if.bip_err_o, '0);
    check("relock_am_cnt", rx_if.err_cnt_o, 66'd1);
    repeat (5) cyc(1'b1, 1'b1, 1'b0, rnd_data());
    cyc(1'b1, 1'b0, 1'b1, mk_am(m_acc ^ 8'h01));
    check("drop_am_err", rx_if.bip_err_o, '0);
    cyc(1'b1, 1'b1, 1'b0, rnd_data());
    lock_m1(8'h33);
    repeat (5) cyc(1'b1, 1'b1, 1'b0, rnd_data());
    cyc(1'b1, 1'b1, 1'b1, mk_am(m_acc ^ 8'h02));
    check("after_relock_cnt", rx_if.err_cnt_o, 66'd2);

    // Idle cycles with garbage and a stray marker strobe must not disturb acc.
    repeat (3) cyc(1'b1, 1'b1, 1'b0, rnd_data());
    cyc(1'b0, 1'b1, 1'b1, mk_am(8'h77));
    cyc(1'b0, 1'b1, 1'b0, rnd_data());
    repeat (3) cyc(1'b1, 1'b1, 1'b0, rnd_data());
    cyc(1'b1, 1'b1, 1'b1, mk_am(m_acc));
    check("idle_hold_err", rx_if.bip_err_o, '0);
    check("idle_hold_cnt", rx_if.err_cnt_o, 66'd2);
    do_reset();

    // Saturation: 65535 bad markers reach all-ones, one more holds and still pulses.
    lock_m1(8'h00);
    for (int i = 0; i < 65535; i++) begin
      if (i % 8192 == 0) cyc(1'b0, 1'b1, 1'b1, rnd_data());
      cyc(1'b1, 1'b1, 1'b1, mk_am(m_acc ^ 8'h01));
    end
    check("sat_reach_cnt", rx_if.err_cnt_o, 66'hFFFF);
    cyc(1'b1, 1'b1, 1'b1, mk_am(m_acc ^ 8'h01));
    check("sat_hold_cnt", rx_if.err_cnt_o, 66'hFFFF);
    check("sat_hold_err", rx_if.bip_err_o, 66'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/am_rm_bip_rx.md
# am_rm_bip_rx

Per-lane receive stage placed directly downstream of the alignment-marker lock stage in the 40G/100G PCS RX path. It consumes locked 66-bit blocks and the marker strobe, checks the BIP-8 carried in each alignment marker against a running parity, and removes markers from the block stream. Its output feeds lane deskew/reorder.

## Interface
- BLOCK_W, 66: block width, 2-bit sync header in [1:0], payload in [65:2].
- CNT_W, 16: BIP error counter width.

- clk  in  1  clock.
- nreset  in  1  reset, asynchronous, active-low.
- valid_i  in  1  block_i valid this cycle (signal_ok).
- block_i  in  BLOCK_W  received block.
- lock_v_i  in  1  upstream marker lock held.
- am_v_i  in  1  block_i is an alignment marker; only meaningful with valid_i & lock_v_i.
- valid_o  out  1  block_o valid; low on marker cycles.
- block_o  out  BLOCK_W  registered copy of block_i.
- bip_err_o  out  1  one-cycle pulse: received BIP3 mismatch.
- err_cnt_o  out  CNT_W  saturating BIP error count.

## Operation
- Marker byte i = block_i[2+8i +: 8]; BIP3 = byte 3, BIP7 = byte 7 (not checked).
- BIP mapping: block bit p (2..65) feeds parity bit (p-2) mod 8; bit 0 feeds parity bit 3, bit 1 feeds parity bit 4. Even parity (XOR).
- Accumulator acc[7:0] covers the previous marker and every data block after it, excluding the current marker.
- States:
  - UNLOCK: acc held at 0; valid_o = 0. Go to WAIT when lock_v_i = 1.
  - WAIT: data blocks pass; acc not compared. On valid_i & am_v_i: acc <= parity(marker), go to RUN, no check.
  - RUN: data block: acc <= acc ^ parity(block). Marker: compare acc to BIP3; mismatch -> bip_err_o next cycle, err_cnt_o + 1 (saturate at all-ones); acc <= parity(marker).
- Any state: lock_v_i = 0 -> UNLOCK, acc cleared, no pulse for that cycle's block. err_cnt_o is not cleared by lock loss.
- valid_i = 0: state, acc and counter hold; valid_o = 0.

## Timing
- Reset: state UNLOCK, acc 0, valid_o 0, block_o 0, bip_err_o 0, err_cnt_o 0.
- Latency 1 cycle: block_i at cycle n appears on block_o, valid_o = valid_i & lock_v_i & ~am_v_i & state != UNLOCK at n+1.
- bip_err_o is asserted at n+1 for a marker at n. The counter updates in the same edge.
- am_v_i with valid_i = 0 is ignored.
- A lock drop in the same cycle as a marker drops the marker: no check, no output.
- Counter at max plus error: holds max, pulse still asserted.
- Cycle after lock asserts: state WAIT, so a marker in that cycle is handled as the WAIT first marker.

## Structure
- Shared PCS package holds: HEAD_W, BLOCK_W, SYNC_CTRL/SYNC_DATA, marker byte indices (BIP3_IDX = 3, BIP7_IDX = 7), and the state enum.
- Sub-module bip8_calc: combinational function, 66-bit block in, 8-bit parity out, per the mapping above. Reusable by the TX marker insertion stage.

## Test plan
- Reset with nreset = 0 mid-stream -> all outputs 0 on the same cycle, state UNLOCK.
- Lock, marker M1, 16383 data blocks, marker M2 with BIP3 = true parity -> bip_err_o never asserted, err_cnt_o = 0; valid_o low exactly on both marker cycles.
- Same sequence, but M2 BIP3 has bit 4 flipped, or header bit 1 of one data block is flipped -> bip_err_o pulse 1 cycle after M2, err_cnt_o = 1.
- First marker after lock carries a wrong BIP3 -> no error; the next wrong marker gives err_cnt_o = 1.
- lock_v_i dropped for one cycle between markers, then a marker follows -> no check on it (WAIT); err_cnt_o unchanged.
- Force err_cnt_o to 16'hFFFF with 65535 bad markers, then one more bad marker -> stays 16'hFFFF, bip_err_o still pulses. Interleave valid_i = 0 cycles and confirm acc holds.
